// File: rtl/alu_pipe_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_mc
// Brief    : N-bit signed ALU with registered result/flags, valid/ready
//            handshake on both sides and a multi-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_mc #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   Cntr,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] R,
    output logic [3:0]   ALUFlags,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int             c_cw    = $clog2(N);
    localparam logic [N-1:0]   c_width = N'(N);
    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]    r_res;
    logic [3:0]      r_flags;
    logic [2*N-1:0]  r_acc;
    logic [2*N-1:0]  r_mcand;
    logic [N-1:0]    r_mplier;
    logic            r_neg;
    logic [c_cw-1:0] r_cnt;

    logic [N:0]          w_sum;
    logic [N-1:0]        w_diff;
    logic [N:0]          w_sll;
    logic signed [N:0]   w_sra;
    logic                w_shamt_big;
    logic [N-1:0]        w_alu_r;
    logic                w_alu_c;
    logic                w_alu_v;
    logic [N-1:0]        w_abs_a;
    logic [N-1:0]        w_abs_b;
    logic [2*N-1:0]      w_acc_sum;
    logic [2*N-1:0]      w_prod;
    logic [N:0]          w_prod_hi;
    logic                w_mul_v;
    logic                w_mul_last;

    assign R        = r_res;
    assign ALUFlags = r_flags;

    // Single-cycle operations, evaluated on the live inputs at the accept edge.
    always_comb begin
        w_sum       = {1'b0, A} + {1'b0, B};
        w_diff      = A - B;
        w_sll       = {1'b0, A} << B;
        w_sra       = $signed({A, 1'b0}) >>> B;
        w_shamt_big = (B >= c_width);
        w_alu_r     = '0;
        w_alu_c     = 1'b0;
        w_alu_v     = 1'b0;
        case (Cntr)
            3'b000: begin
                w_alu_r = w_sum[N-1:0];
                w_alu_c = w_sum[N];
                w_alu_v = (A[N-1] == B[N-1]) && (w_sum[N-1] != A[N-1]);
            end
            3'b001: begin
                w_alu_r = w_diff;
                w_alu_c = (A >= B);
                w_alu_v = (A[N-1] != B[N-1]) && (w_diff[N-1] != A[N-1]);
            end
            3'b010: w_alu_r = A & B;
            3'b011: w_alu_r = A | B;
            3'b100: w_alu_r = A ^ B;
            3'b101: begin
                // The extra MSB of w_sll catches the last bit shifted out.
                if (B == '0) begin
                    w_alu_r = A;
                end else if (!w_shamt_big) begin
                    w_alu_r = w_sll[N-1:0];
                    w_alu_c = w_sll[N];
                end
            end
            3'b110: begin
                // The extra LSB of w_sra catches the last bit shifted out.
                if (B == '0) begin
                    w_alu_r = A;
                end else if (!w_shamt_big) begin
                    w_alu_r = w_sra[N:1];
                    w_alu_c = w_sra[0];
                end else begin
                    w_alu_r = {N{A[N-1]}};
                end
            end
            default: w_alu_r = '0;
        endcase
    end

    // Magnitudes fit in N unsigned bits, including |-2^(N-1)|.
    assign w_abs_a = A[N-1] ? (~A + 1'b1) : A;
    assign w_abs_b = B[N-1] ? (~B + 1'b1) : B;

    assign w_acc_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? (~w_acc_sum + 1'b1) : w_acc_sum;
    assign w_prod_hi  = w_prod[2*N-1:N-1];
    assign w_mul_v    = !((&w_prod_hi) || !(|w_prod_hi));
    assign w_mul_last = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = (Cntr == 3'b111) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res    <= '0;
            r_flags  <= 4'b0000;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (Cntr == 3'b111) begin
                            r_acc    <= '0;
                            r_mcand  <= {{N{1'b0}}, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_neg    <= A[N-1] ^ B[N-1];
                            r_cnt    <= '0;
                        end else begin
                            r_res   <= w_alu_r;
                            r_flags <= {w_alu_r[N-1], (w_alu_r == '0), w_alu_c, w_alu_v};
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_res   <= w_prod[N-1:0];
                        r_flags <= {w_prod[N-1], (w_prod[N-1:0] == '0), 1'b0, w_mul_v};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe_mc.md
Name: alu_pipe_mc

Overview:
Parametrised N-bit signed ALU and the next generation of the lab combinational ALU. It adds registered outputs, a valid/ready handshake on input and output, and a multi-cycle shift-add signed multiplier. It sits between an operand source (register file or test sequencer) and a result sink. The sink may apply backpressure.

Parameters:
N, 8, operand/result width in bits (N >= 4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
A  in  N  signed operand A
B  in  N  signed operand B (unsigned shift amount for shift ops)
Cntr  in  3  operation select
in_valid  in  1  operands/Cntr valid
in_ready  out  1  block can accept an operation
R  out  N  signed result (registered)
ALUFlags  out  4  {N,Z,C,V}, registered with R
out_valid  out  1  R/ALUFlags valid
out_ready  in  1  sink accepts result

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst=1 at an edge forces state=IDLE, R=0, ALUFlags=0000, out_valid=0, in_ready=1 after that edge. Reset overrides any in-flight op, including a MUL or a held result; that op is discarded.
- Operand capture: an op is accepted on an edge where in_valid && in_ready. A, B and Cntr are captured at that edge; later input changes have no effect.
- Cntr encoding:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL (A << B)
  - 110 SRA (A >>> B)
  - 111 MUL (signed A*B)
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept of a non-MUL op: compute, load R/ALUFlags, go to DONE. On accept of MUL: go to MUL.
  - MUL: in_ready=0. Unsigned shift-add on |A|, |B| over N cycles (one partial-product step per cycle). Cycle counter runs 0..N-1. Go to DONE after step N-1, loading R/ALUFlags.
  - DONE: out_valid=1, in_ready=0. R/ALUFlags held stable. On out_ready=1, go to IDLE. No accept in the same cycle.
- Latency (accept edge = T):
  - Non-MUL: out_valid=1 from T+1.
  - MUL: out_valid=1 from T+N+1.
- Backpressure: out_valid stays high and R/ALUFlags stay constant for as long as out_ready=0 in DONE. No result is ever dropped.
- Flags: N=R[N-1]; Z=(R==0).
  - ADD: C=carry out of unsigned N-bit add. V=operands same sign and result sign differs.
  - SUB: C=1 iff unsigned A >= unsigned B (no borrow). V=operands differ in sign and result sign differs from A.
  - AND/OR/XOR: C=0, V=0.
  - SLL/SRA: shamt=B as unsigned.
    - shamt=0: R=A, C=0.
    - 1 <= shamt <= N-1: C=last bit shifted out (SLL: A[N-shamt]; SRA: A[shamt-1]).
    - shamt >= N: SLL R=0, SRA R={N{A[N-1]}}, C=0.
    - V=0.
  - MUL: full 2N-bit signed product P. Magnitude product is negated if A[N-1]^B[N-1]. R=P[N-1:0]. C=0. V=1 iff P is not representable in N-bit signed (P[2N-1:N-1] not all equal).
- Width rules: all arithmetic is modulo 2^N. The magnitude of -2^(N-1) is 2^(N-1) and is held in an N-bit unsigned register without loss.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-MUL (A=20, B=-6, accepted 3 cycles earlier) -> next cycle out_valid=0, R=0, ALUFlags=0000, in_ready=1. A following ADD 15+10 -> R=25, flags 0000 at T+1.
- ADD/SUB flags (N=8):
  - ADD 127+1 -> R=-128, flags 1001.
  - ADD -1+1 -> R=0, flags 0110.
  - SUB -120-88 -> R=48, flags 0011.
  - SUB 15-(-10) -> R=25, flags 0000.
- MUL:
  - 20*(-6) -> R=-120, flags 1000, out_valid first high at T+9, in_ready=0 during T+1..T+9.
  - 20*10 -> R=-56 (0xC8), flags 1001.
  - -128*-1 -> R=-128, V=1.
- Shifts:
  - SRA -76 by 3 -> R=-10, flags 1010.
  - SLL 0x81 by 1 -> R=0x02, flags 0010.
  - SLL 5 by 9 -> R=0, flags 0100.
  - SRA -76 by 0 -> R=-76, flags 1000.
- Logic ops: AND 0xF0,0x3C -> 0x30. OR 0xF0,0x0F -> 0xFF, flags 1000. XOR 0x5A,0x5A -> 0, flags 0100.
- Backpressure/handshake: hold out_ready=0 for 5 cycles after an ADD result.
  - R/ALUFlags/out_valid stable throughout; in_ready=0; in_valid pulses with new operands are ignored.
  - Raise out_ready -> IDLE next cycle, in_ready=1.
  - The next op is accepted no earlier than 2 cycles after the first result appeared.
